alu_ctrl_seq: RTL and testbench

- Registered, handshaked successor of the combinational ALU control decoder.
- Decodes {ALUOp, funct} into the ALU's Funct code.
- Sequences multi-cycle operations (multu) by holding the result back for a parametrised latency.
- Sits between the decode stage and the ALU; supports stall/backpressure via valid/ready on both sides.

---
 rtl/alu_ctrl_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked ALU control decoder.
//   Decodes {ALUOp, funct} into the ALU Funct code. Single-cycle ops are presented
//   one cycle after accept. multu is held in a wait state for MUL_LAT cycles first.
//   Result is held while out_ready is low, and in_ready drops until the result retires.
// Ports:
//   clk, rst                      - clock (rising edge), synchronous active-high reset
//   in_valid/in_ready, funct, ALUOp  - request side; inputs sampled only on accept
//   out_valid/out_ready, Funct, illegal - result side; illegal=1 forces Funct=0
//   busy                          - high while a multu waits out its latency
// Optional (macro ALU_CTRL_PERF_EN): op_count, illegal_count saturating 16-bit retire counters.
module alu_ctrl_seq #(
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 2,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [ALUOP_W-1:0] ALUOp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FUNCT_W-1:0] Funct,
    output logic               illegal,
    output logic               busy
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [15:0]        op_count,
    output logic [15:0]        illegal_count
`endif
);

    localparam logic [FUNCT_W-1:0] F_ADDU  = FUNCT_W'(6'b001011);
    localparam logic [FUNCT_W-1:0] F_SUBU  = FUNCT_W'(6'b001101);
    localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b010010);
    localparam logic [FUNCT_W-1:0] F_SLL   = FUNCT_W'(6'b100110);
    localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MWAIT = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [FUNCT_W-1:0] r_funct;
    logic               r_illegal;

    logic [FUNCT_W-1:0] w_dec_funct;
    logic               w_dec_illegal;
    logic               w_dec_multi;
    logic               w_accept;
    logic               w_retire;

    // Combinational decode of the live request; only captured on accept.
    always_comb begin
        w_dec_funct   = '0;
        w_dec_illegal = 1'b1;
        w_dec_multi   = 1'b0;
        if (ALUOp == ALUOP_W'(2'b00)) begin
            w_dec_funct   = F_SUBU;
            w_dec_illegal = 1'b0;
        end else if (ALUOp == ALUOP_W'(2'b01)) begin
            w_dec_funct   = F_ADDU;
            w_dec_illegal = 1'b0;
        end else if (ALUOp == ALUOP_W'(2'b10)) begin
            if (funct == F_ADDU || funct == F_SUBU || funct == F_AND ||
                funct == F_SLL  || funct == F_MULTU) begin
                w_dec_funct   = funct;
                w_dec_illegal = 1'b0;
                w_dec_multi   = (funct == F_MULTU);
            end
        end
    end

    // A result slot frees up in the same cycle it retires, giving 1 op/cycle.
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_OUT) && out_ready);
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state == S_MWAIT);
    assign Funct     = r_funct;
    assign illegal   = r_illegal;
    assign w_accept  = in_valid && in_ready;
    assign w_retire  = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_MWAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_OUT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready && !w_accept) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: ;
        endcase
        // Accept overrides the above; covers both IDLE and retire-plus-accept in OUT.
        if (w_accept) begin
            if (w_dec_multi) begin
                w_state_nxt = S_MWAIT;
                w_cnt_nxt   = CNT_W'(MUL_LAT - 1);
            end else begin
                w_state_nxt = S_OUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_funct   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_funct   <= w_dec_funct;
                r_illegal <= w_dec_illegal;
            end
        end
    end

`ifdef ALU_CTRL_PERF_EN
    logic [15:0] r_op_count;
    logic [15:0] r_illegal_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count      <= '0;
            r_illegal_count <= '0;
        end else if (w_retire) begin
            if (r_op_count != 16'hFFFF) begin
                r_op_count <= r_op_count + 16'd1;
            end
            if (r_illegal && (r_illegal_count != 16'hFFFF)) begin
                r_illegal_count <= r_illegal_count + 16'd1;
            end
        end
    end

    assign op_count      = r_op_count;
    assign illegal_count = r_illegal_count;
`else
    logic w_unused;
    assign w_unused = w_retire;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;
    localparam int FW      = 6;
    localparam int AW      = 2;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [FW-1:0] funct = '0;
    logic [AW-1:0] ALUOp = '0;
    logic          in_ready;
    logic          out_valid;
    logic [FW-1:0] Funct;
    logic          illegal;
    logic          busy;
`ifdef ALU_CTRL_PERF_EN
    logic [15:0]   op_count;
    logic [15:0]   illegal_count;
`endif

    alu_ctrl_seq #(.FUNCT_W(FW), .ALUOP_W(AW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .funct(funct), .ALUOp(ALUOp),
        .out_valid(out_valid), .out_ready(out_ready), .Funct(Funct), .illegal(illegal),
        .busy(busy)
`ifdef ALU_CTRL_PERF_EN
        , .op_count(op_count), .illegal_count(illegal_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [5:0] legal_r [5] = '{6'b001011, 6'b001101, 6'b010010, 6'b100110, 6'b011001};

    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                       output logic [5:0] rf, output logic ri, output bit rm);
        rf = '0; ri = 1'b1; rm = 1'b0;
        if (op == 2'b00) begin rf = 6'b001101; ri = 1'b0; end
        else if (op == 2'b01) begin rf = 6'b001011; ri = 1'b0; end
        else if (op == 2'b10) begin
            foreach (legal_r[i]) if (f == legal_r[i]) begin rf = f; ri = 1'b0; end
            rm = (f == 6'b011001);
        end
    endfunction

    // One op in flight; it becomes visible at cycle m_valid_cyc.
    bit         m_known = 1'b0;
    bit         m_has   = 1'b0;
    int         cyc     = 0;
    int         m_valid_cyc = 0;
    logic [5:0] m_funct = '0;
    logic       m_ill   = 1'b0;
    int         m_ops   = 0;
    int         m_ills  = 0;
    bit         s_rst = 1'b0, s_acc = 1'b0, s_ret = 1'b0;
    logic [1:0] s_op = '0;
    logic [5:0] s_f  = '0;

    always @(negedge clk) begin
        bit ov, rdy;
        ov  = m_has && (cyc >= m_valid_cyc);
        rdy = !m_has || (ov && out_ready);
        if (m_known) begin
            chk("mdl_out_valid", out_valid, ov);
            chk("mdl_in_ready", in_ready, rdy);
            chk("mdl_busy", busy, m_has && !ov);
            if (ov) begin
                chk("mdl_Funct", Funct, m_funct);
                chk("mdl_illegal", illegal, m_ill);
            end
`ifdef ALU_CTRL_PERF_EN
            chk("mdl_op_count", op_count, m_ops);
            chk("mdl_illegal_count", illegal_count, m_ills);
`endif
        end
        s_rst = rst;
        s_acc = in_valid && rdy;
        s_ret = ov && out_ready;
        s_op  = ALUOp;
        s_f   = funct;
    end

    always @(posedge clk) begin
        bit mul;
        cyc = cyc + 1;
        if (s_rst) begin
            m_known = 1'b1; m_has = 1'b0; m_ops = 0; m_ills = 0;
        end else if (m_known) begin
            if (s_ret) begin
                m_has = 1'b0;
                if (m_ops < 65535) m_ops++;
                if (m_ill && m_ills < 65535) m_ills++;
            end
            if (s_acc) begin
                ref_decode(s_op, s_f, m_funct, m_ill, mul);
                m_has = 1'b1;
                m_valid_cyc = cyc + (mul ? MUL_LAT : 0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_Funct", Funct, 0);
        chk("rst_illegal", illegal, 0);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [5:0] f,
                          input logic [5:0] ef, input logic ei, input int elat);
        int lat;
        ALUOp = op; funct = f; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        ALUOp = 2'($urandom); funct = 6'($urandom);
        lat = 0;
        #1;
        while (!out_valid && lat < 40) begin
            chk({name, "_wait_busy"}, busy, 1);
            chk({name, "_wait_in_ready"}, in_ready, 0);
            tick(); lat++; #1;
        end
        chk({name, "_latency"}, lat, elat);
        chk({name, "_Funct"}, Funct, ef);
        chk({name, "_illegal"}, illegal, ei);
        tick(); #1;
        chk({name, "_retired"}, out_valid, 0);
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [5:0] f;
        logic [5:0] ef;
        logic       ei;
        int         lat;
    } vec_t;
    vec_t vt [9];

    initial begin
        int lat;
        vt[0] = '{"addu",   2'b10, 6'b001011, 6'b001011, 1'b0, 0};
        vt[1] = '{"subu",   2'b10, 6'b001101, 6'b001101, 1'b0, 0};
        vt[2] = '{"and",    2'b10, 6'b010010, 6'b010010, 1'b0, 0};
        vt[3] = '{"sll",    2'b10, 6'b100110, 6'b100110, 1'b0, 0};
        vt[4] = '{"multu",  2'b10, 6'b011001, 6'b011001, 1'b0, MUL_LAT};
        vt[5] = '{"op00",   2'b00, 6'b111010, 6'b001101, 1'b0, 0};
        vt[6] = '{"op01",   2'b01, 6'b011001, 6'b001011, 1'b0, 0};
        vt[7] = '{"op11",   2'b11, 6'b001011, 6'b000000, 1'b1, 0};
        vt[8] = '{"rbad",   2'b10, 6'b000000, 6'b000000, 1'b1, 0};

        do_reset();

        // Two illegal requests straight after reset.
        run_op("ill_op11", 2'b11, 6'b010010, 6'b0, 1'b1, 0);
        run_op("ill_f3f",  2'b10, 6'b111111, 6'b0, 1'b1, 0);
`ifdef ALU_CTRL_PERF_EN
        chk("perf_op_count", op_count, 2);
        chk("perf_illegal_count", illegal_count, 2);
`endif

        for (int i = 0; i < 9; i++)
            run_op(vt[i].name, vt[i].op, vt[i].f, vt[i].ef, vt[i].ei, vt[i].lat);

        // multu with a competing request held during MWAIT.
        ALUOp = 2'b10; funct = 6'b011001; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        ALUOp = 2'b01;
        lat = 0; #1;
        while (!out_valid && lat < 40) begin
            chk("mw_in_ready", in_ready, 0);
            chk("mw_busy", busy, 1);
            tick(); lat++; #1;
        end
        chk("mw_latency", lat, MUL_LAT);
        chk("mw_Funct", Funct, 6'b011001);
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); #1;
        chk("mw_no_second", out_valid, 0);

        // Back-to-back single-cycle ops.
        out_ready = 1'b1;
        ALUOp = 2'b00; in_valid = 1'b1;
        tick();
        ALUOp = 2'b01; #1;
        chk("b2b_v0", out_valid, 1); chk("b2b_f0", Funct, 6'b001101); chk("b2b_r0", in_ready, 1);
        tick();
        ALUOp = 2'b10; funct = 6'b100110; #1;
        chk("b2b_v1", out_valid, 1); chk("b2b_f1", Funct, 6'b001011); chk("b2b_r1", in_ready, 1);
        tick();
        in_valid = 1'b0; #1;
        chk("b2b_v2", out_valid, 1); chk("b2b_f2", Funct, 6'b100110); chk("b2b_r2", in_ready, 1);
        tick(); #1;
        chk("b2b_done", out_valid, 0);

        // Backpressure hold.
        ALUOp = 2'b10; funct = 6'b010010; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; funct = 6'b001011;
        repeat (3) begin
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_Funct", Funct, 6'b010010);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1; #1;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 1);
        tick(); #1;
        chk("bp_done", out_valid, 0);

        // Reset in the second MWAIT cycle aborts the op.
        ALUOp = 2'b10; funct = 6'b011001; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick(); #1;
        chk("rmid_out_valid", out_valid, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_in_ready", in_ready, 1);
        chk("rmid_Funct", Funct, 0);
        rst = 1'b0;
        repeat (8) begin
            tick(); #1;
            chk("rmid_no_retire", out_valid, 0);
        end

        // Randomized traffic, checked cycle by cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = 1'($urandom);
            ALUOp     = 2'($urandom);
            funct     = ($urandom_range(0, 1) == 1) ? legal_r[$urandom_range(0, 4)] : 6'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (MUL_LAT + 4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
